// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: command bytes, FSM states and word geometry shared by the loader
package imem_loader_pkg;
  localparam logic [7:0] DEF_CMD_LOAD = 8'h4C;
  localparam logic [7:0] DEF_CMD_RUN = 8'h52;
  localparam logic [7:0] DEF_CMD_STEP = 8'h53;
  localparam logic [7:0] DEF_CMD_HALT = 8'h48;
  localparam int BYTES_PER_WORD = 4;
  typedef enum logic [1:0] {IDLE, LEN, DATA, RUN} state_t;
endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: shifts received bytes little-endian into a 32-bit word
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        strobe,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        word_done
);
  logic [$clog2(BYTES_PER_WORD)-1:0] cnt;
  // word_done flags the strobe that completes a word, a cycle ahead of word_valid
  assign word_done = strobe && cnt == ($clog2(BYTES_PER_WORD))'(BYTES_PER_WORD - 1);
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
      word <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= word_done;
      if (strobe) begin
        cnt <= cnt + 1'b1;
        word <= {byte_in, word[31:8]};
      end
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte-command boot/debug controller driving the imem write port and CPU run control
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8,
  parameter int TIMEOUT = 100000,
  parameter logic [7:0] CMD_LOAD = DEF_CMD_LOAD,
  parameter logic [7:0] CMD_RUN = DEF_CMD_RUN,
  parameter logic [7:0] CMD_STEP = DEF_CMD_STEP,
  parameter logic [7:0] CMD_HALT = DEF_CMD_HALT
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_cpu_halt,
  output logic               o_we,
  output logic [NB_ADDR-1:0] o_inst_addr,
  output logic [NB_DATA-1:0] o_inst_data,
  output logic               o_halt,
  output logic               o_cpu_reset,
  output logic               o_busy,
  output logic               o_load_done,
  output logic               o_error,
  output logic [NB_ADDR:0]   o_words_loaded
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [NB_ADDR:0] words_left, words_left_n, words_total, words_total_n, loaded_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [NB_ADDR-1:0] addr_n;
  logic halt_n, cpu_reset_n, error_n, load_done_n, clear, word_done;
  word_assembler u_asm (
    .clk(clk),
    .rst(i_reset),
    .byte_in(i_rx_data),
    .strobe(i_rx_valid && state == DATA),
    .clear(clear),
    .word(o_inst_data),
    .word_valid(o_we),
    .word_done(word_done)
  );
  always_comb begin
    state_n = state;
    words_left_n = words_left;
    words_total_n = words_total;
    loaded_n = o_words_loaded;
    tcnt_n = '0;
    halt_n = o_halt;
    cpu_reset_n = o_cpu_reset;
    error_n = 1'b0;
    load_done_n = 1'b0;
    clear = 1'b0;
    addr_n = o_we ? o_inst_addr + 1'b1 : o_inst_addr;
    case (state)
      IDLE: begin
        halt_n = 1'b1;
        if (i_rx_valid) begin
          if (i_rx_data == CMD_LOAD) begin
            state_n = LEN;
            cpu_reset_n = 1'b1;
          end else if (i_rx_data == CMD_RUN || i_rx_data == CMD_STEP) begin
            state_n = i_rx_data == CMD_RUN ? RUN : IDLE;
            cpu_reset_n = 1'b0;
            halt_n = 1'b0;
          end else if (i_rx_data != CMD_HALT) begin
            error_n = 1'b1;
          end
        end
      end
      LEN, DATA: begin
        tcnt_n = i_rx_valid ? '0 : tcnt + 1'b1;
        // a byte arriving in the expiry cycle keeps the load alive
        if (!i_rx_valid && tcnt == TW'(TIMEOUT - 1)) begin
          state_n = IDLE;
          error_n = 1'b1;
        end else if (state == LEN && i_rx_valid) begin
          words_total_n = i_rx_data == 8'd0 ? (NB_ADDR + 1)'(1 << NB_ADDR) : (NB_ADDR + 1)'(i_rx_data);
          words_left_n = words_total_n;
          addr_n = '0;
          clear = 1'b1;
          state_n = DATA;
        end else if (word_done) begin
          words_left_n = words_left - 1'b1;
          if (words_left == (NB_ADDR + 1)'(1)) begin
            state_n = IDLE;
            load_done_n = 1'b1;
            loaded_n = words_total;
          end
        end
      end
      RUN: begin
        halt_n = 1'b0;
        cpu_reset_n = 1'b0;
        if (i_cpu_halt || (i_rx_valid && i_rx_data == CMD_HALT)) begin
          state_n = IDLE;
          halt_n = 1'b1;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state <= IDLE;
      words_left <= '0;
      words_total <= '0;
      tcnt <= '0;
      o_inst_addr <= '0;
      o_halt <= 1'b1;
      o_cpu_reset <= 1'b1;
      o_busy <= 1'b0;
      o_load_done <= 1'b0;
      o_error <= 1'b0;
      o_words_loaded <= '0;
    end else begin
      state <= state_n;
      words_left <= words_left_n;
      words_total <= words_total_n;
      tcnt <= tcnt_n;
      o_inst_addr <= addr_n;
      o_halt <= halt_n;
      o_cpu_reset <= cpu_reset_n;
      o_busy <= state_n == LEN || state_n == DATA;
      o_load_done <= load_done_n;
      o_error <= error_n;
      o_words_loaded <= loaded_n;
    end
  end
endmodule
